csr_pending_tracker: RTL and testbench
======================================

Name: csr_pending_tracker

Overview:
- Per-warp in-flight instruction tracker sitting directly upstream of the CSR unit.
- Drives the scheduler/CSR-side `alm_empty` answer for a queried warp, so FPU-CSR accesses (fflags/frm/fcsr) only proceed once all older instructions of that warp have drained.
- Owns the per-warp lock that stalls issue from the moment an FPU-CSR instruction issues until the CSR unit returns `unlock_warp`.

Parameters:
- NUM_WARPS, 4, number of warps tracked (>=1).
- NW_WIDTH, max(1,clog2(NUM_WARPS)), warp-id width.
- CNT_WIDTH, 4, per-warp counter width; max pending = 2^CNT_WIDTH-1.
- TOT_WIDTH, CNT_WIDTH+clog2(NUM_WARPS), width of the total-pending count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction issued this cycle.
- issue_wid  in  NW_WIDTH  warp of the issued instruction.
- issue_lock  in  1  issued instruction is an FPU-CSR access (lock, no count).
- issue_ready  out  1  issue accepted for issue_wid.
- commit_valid  in  1  a tracked instruction completes.
- commit_wid  in  NW_WIDTH  warp of the completing instruction.
- alm_empty_wid  in  NW_WIDTH  warp being queried by the CSR unit.
- alm_empty  out  1  queried warp has no older pending work.
- unlock_warp  in  1  CSR unit releases a lock.
- unlock_wid  in  NW_WIDTH  warp to release.
- locked_mask  out  NUM_WARPS  registered per-warp lock state.
- total_pending  out  TOT_WIDTH  registered sum of all counters.
- underflow_err  out  1  sticky: commit_valid seen while the target counter was 0.

Behaviour:
- Reset (reset==0, async):
  - all counters = 0, locked_mask = 0, total_pending = 0, underflow_err = 0.
  - issue_ready and alm_empty follow combinationally from the cleared state, so both read 1 during reset.
  - Reset asserted mid-operation discards all in-flight state; no commit is replayed afterwards.
- issue_ready = ~locked_mask[issue_wid] && (issue_lock || cnt[issue_wid] != MAX). Combinational; it must not depend on issue_valid.
- issue_fire = issue_valid && issue_ready. Transfers not fired are ignored; no state changes.
- Non-lock fire: cnt[issue_wid] += 1 at the next edge.
- Lock fire: locked_mask[issue_wid] <= 1; counter unchanged, because the CSR op is not self-tracked.
- Commit:
  - if cnt[commit_wid] > 0, decrement at the next edge;
  - if cnt[commit_wid] == 0, the counter stays 0 and underflow_err <= 1 (sticky until reset).
  - commit_valid has no ready; it is always consumed.
- Issue fire (non-lock) and commit in the same cycle:
  - same wid: counter unchanged (net 0). In the MAX case the issue is already blocked; with cnt 0, increment and decrement cancel and no underflow is flagged.
  - different wid: both apply independently.
- alm_empty = (cnt[q]==0) || (cnt[q]==1 && commit_valid && commit_wid==q), where q = alm_empty_wid. Combinational, zero-cycle.
- Unlock:
  - unlock_warp clears locked_mask[unlock_wid] at the next edge.
  - Unlocking an unlocked warp is a no-op, not an error.
  - A lock fire and an unlock to the same wid in the same cycle: the lock wins and the bit ends at 1.
- total_pending is registered and equals the sum of the next-state counters, so it matches the counters one cycle after any update.
- Latency:
  - counters and the lock become visible 1 cycle after the event;
  - issue_ready for a warp drops in the cycle after its lock fire.
- Counter arithmetic is unsigned, CNT_WIDTH bits. Overflow is impossible by construction, because issue_ready gates it at MAX.

Test Plan:
- Reset, then NUM_WARPS=4: issue 3 non-lock instructions to wid 2 -> cnt[2]=3, total_pending=3, alm_empty(wid 2)=0, alm_empty(wid 1)=1.
- Fill wid 0 to 15 (CNT_WIDTH=4) -> issue_ready=0 for wid 0. Same cycle, commit to wid 0 plus issue to wid 0 -> issue still rejected, cnt=14 next cycle. Next cycle, issue + commit to wid 0 -> cnt stays 14.
- cnt[1]=1, alm_empty_wid=1, commit_valid to wid 1 in the same cycle -> alm_empty=1 that cycle; cnt[1]=0 next cycle.
- Lock issue on wid 3 -> locked_mask=4'b1000, issue_ready=0 for wid 3, counter unchanged. unlock_warp wid 3 -> mask 0 next cycle. Lock and unlock to wid 3 in the same cycle -> mask bit stays 1.
- Commit to wid 1 with cnt 0 -> underflow_err=1 and stays 1; cnt[1]=0. Assert reset -> underflow_err=0.
- With cnt[2]=5 and wid 0 locked, assert reset asynchronously mid-cycle -> all counters, locked_mask and total_pending read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/csr_pending_tracker.sv
// Per-warp in-flight instruction counters and FPU-CSR issue locks feeding the
// CSR unit's alm_empty query and the scheduler's issue_ready.
module csr_pending_tracker #(
    parameter int NUM_WARPS = 4,
    parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CNT_WIDTH = 4,
    parameter int TOT_WIDTH = CNT_WIDTH + $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [NW_WIDTH-1:0]  issue_wid,
    input  logic                 issue_lock,
    output logic                 issue_ready,
    input  logic                 commit_valid,
    input  logic [NW_WIDTH-1:0]  commit_wid,
    input  logic [NW_WIDTH-1:0]  alm_empty_wid,
    output logic                 alm_empty,
    input  logic                 unlock_warp,
    input  logic [NW_WIDTH-1:0]  unlock_wid,
    output logic [NUM_WARPS-1:0] locked_mask,
    output logic [TOT_WIDTH-1:0] total_pending,
    output logic                 underflow_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_r      [NUM_WARPS];
    logic [CNT_WIDTH-1:0] cnt_next_s [NUM_WARPS];
    logic [NUM_WARPS-1:0] issue_sel_s;
    logic [NUM_WARPS-1:0] commit_sel_s;
    logic [NUM_WARPS-1:0] query_sel_s;
    logic [NUM_WARPS-1:0] unlock_sel_s;
    logic [NUM_WARPS-1:0] ready_vec_s;
    logic [NUM_WARPS-1:0] empty_vec_s;
    logic [NUM_WARPS-1:0] inc_s;
    logic [NUM_WARPS-1:0] dec_s;
    logic [NUM_WARPS-1:0] underflow_hit_s;
    logic [NUM_WARPS-1:0] lock_next_s;
    logic [TOT_WIDTH-1:0] total_next_s;
    logic                 issue_fire_s;

    // One-hot warp decode; out-of-range ids select nothing
    always_comb begin
        issue_sel_s  = '0;
        commit_sel_s = '0;
        query_sel_s  = '0;
        unlock_sel_s = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            issue_sel_s[w]  = (issue_wid     == NW_WIDTH'(w));
            commit_sel_s[w] = (commit_wid    == NW_WIDTH'(w));
            query_sel_s[w]  = (alm_empty_wid == NW_WIDTH'(w));
            unlock_sel_s[w] = (unlock_wid    == NW_WIDTH'(w));
        end
    end

    // Issue acceptance and zero-cycle drain query; a commit landing on the
    // last pending instruction already counts as drained
    always_comb begin
        ready_vec_s = '0;
        empty_vec_s = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_vec_s[w] = ~locked_mask[w] & (issue_lock | (cnt_r[w] != CNT_MAX));
            empty_vec_s[w] = (cnt_r[w] == CNT_ZERO) |
                             ((cnt_r[w] == CNT_ONE) & commit_valid & commit_sel_s[w]);
        end
        issue_ready  = |(ready_vec_s & issue_sel_s);
        alm_empty    = |(empty_vec_s & query_sel_s);
        issue_fire_s = issue_valid & issue_ready;
    end

    // Next-state counters, locks and total; a same-warp issue cancels a
    // commit so an empty counter with both events never flags underflow
    always_comb begin
        total_next_s    = '0;
        inc_s           = '0;
        dec_s           = '0;
        underflow_hit_s = '0;
        lock_next_s     = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc_s[w]           = issue_fire_s & ~issue_lock & issue_sel_s[w];
            dec_s[w]           = commit_valid & commit_sel_s[w];
            underflow_hit_s[w] = dec_s[w] & ~inc_s[w] & (cnt_r[w] == CNT_ZERO);
            case ({inc_s[w], dec_s[w]})
                2'b10:   cnt_next_s[w] = cnt_r[w] + CNT_ONE;
                2'b01:   cnt_next_s[w] = (cnt_r[w] != CNT_ZERO) ? (cnt_r[w] - CNT_ONE) : cnt_r[w];
                default: cnt_next_s[w] = cnt_r[w];
            endcase
            lock_next_s[w] = (issue_fire_s & issue_lock & issue_sel_s[w]) |
                             (locked_mask[w] & ~(unlock_warp & unlock_sel_s[w]));
            total_next_s   = total_next_s + TOT_WIDTH'(cnt_next_s[w]);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= CNT_ZERO;
            end
            locked_mask   <= '0;
            total_pending <= '0;
            underflow_err <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_r[w] <= cnt_next_s[w];
            end
            locked_mask   <= lock_next_s;
            total_pending <= total_next_s;
            underflow_err <= underflow_err | (|underflow_hit_s);
        end
    end

endmodule

// File: tb/tb_csr_pending_tracker.sv
// Directed plus randomized bench for csr_pending_tracker, compared against a
// per-warp integer reference model of the pending/lock rules.
module tb_csr_pending_tracker;

    localparam int NW  = 4;
    localparam int MAXC = 15;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [1:0]  issue_wid;
    logic        issue_lock;
    logic        issue_ready;
    logic        commit_valid;
    logic [1:0]  commit_wid;
    logic [1:0]  alm_empty_wid;
    logic        alm_empty;
    logic        unlock_warp;
    logic [1:0]  unlock_wid;
    logic [3:0]  locked_mask;
    logic [5:0]  total_pending;
    logic        underflow_err;

    int          pass_cnt;
    int          total_cnt;
    int          cnt_m [NW];
    bit   [3:0]  lock_m;
    bit          uf_m;

    csr_pending_tracker dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_wid     (issue_wid),
        .issue_lock    (issue_lock),
        .issue_ready   (issue_ready),
        .commit_valid  (commit_valid),
        .commit_wid    (commit_wid),
        .alm_empty_wid (alm_empty_wid),
        .alm_empty     (alm_empty),
        .unlock_warp   (unlock_warp),
        .unlock_wid    (unlock_wid),
        .locked_mask   (locked_mask),
        .total_pending (total_pending),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) cnt_m[w] = 0;
        lock_m = 4'b0000;
        uf_m   = 1'b0;
    endtask

    function automatic bit m_ready(input int iw, input bit il);
        return !lock_m[iw] && (il || cnt_m[iw] != MAXC);
    endfunction

    function automatic bit m_empty(input int q, input bit cv, input int cw);
        return (cnt_m[q] == 0) || (cnt_m[q] == 1 && cv && cw == q);
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int w = 0; w < NW; w++) s += cnt_m[w];
        return s;
    endfunction

    task automatic model_step(input bit iv, input int iw, input bit il,
                              input bit cv, input int cw, input bit uv, input int uw);
        bit fire;
        bit inc;
        int old [NW];
        fire = iv && m_ready(iw, il);
        inc  = fire && !il;
        for (int w = 0; w < NW; w++) old[w] = cnt_m[w];
        if (inc) cnt_m[iw] = cnt_m[iw] + 1;
        if (cv) begin
            if (inc && iw == cw) cnt_m[cw] = cnt_m[cw] - 1;
            else if (old[cw] > 0) cnt_m[cw] = cnt_m[cw] - 1;
            else uf_m = 1'b1;
        end
        if (uv) lock_m[uw] = 1'b0;
        if (fire && il) lock_m[iw] = 1'b1;
    endtask

    // Drive one cycle of inputs, check combinational answers, clock, check state
    task automatic cycle(input bit iv, input int iw, input bit il,
                         input bit cv, input int cw, input int q,
                         input bit uv, input int uw);
        issue_valid   = iv;
        issue_wid     = 2'(iw);
        issue_lock    = il;
        commit_valid  = cv;
        commit_wid    = 2'(cw);
        alm_empty_wid = 2'(q);
        unlock_warp   = uv;
        unlock_wid    = 2'(uw);
        #1;
        chk("issue_ready", 32'(issue_ready), 32'(m_ready(iw, il)));
        chk("alm_empty", 32'(alm_empty), 32'(m_empty(q, cv, cw)));
        @(posedge clk);
        model_step(iv, iw, il, cv, cw, uv, uw);
        #1;
        chk("locked_mask", 32'(locked_mask), 32'(lock_m));
        chk("total_pending", 32'(total_pending), 32'(m_total()));
        chk("underflow_err", 32'(underflow_err), 32'(uf_m));
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        model_reset();
        reset = 1'b0;
        issue_valid = 1'b0; issue_wid = 2'd0; issue_lock = 1'b0;
        commit_valid = 1'b0; commit_wid = 2'd0; alm_empty_wid = 2'd0;
        unlock_warp = 1'b0; unlock_wid = 2'd0;
        #2;
        chk("rst_locked_mask", 32'(locked_mask), 32'd0);
        chk("rst_total", 32'(total_pending), 32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_alm_empty", 32'(alm_empty), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Three issues to warp 2, then query warps 2 and 1
        for (int i = 0; i < 3; i++) cycle(1'b1, 2, 1'b0, 1'b0, 0, 2, 1'b0, 0);
        chk("w2_total", 32'(total_pending), 32'd3);
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 2, 1'b0, 0);
        chk("w2_alm_empty", 32'(alm_empty), 32'd0);
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 1, 1'b0, 0);
        chk("w1_alm_empty", 32'(alm_empty), 32'd1);

        // Fill warp 0 to MAX; issue blocked even with a same-cycle commit
        for (int i = 0; i < MAXC; i++) cycle(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        cycle(1'b1, 0, 1'b0, 1'b1, 0, 0, 1'b0, 0);
        chk("w0_full_total", 32'(total_pending), 32'd17);
        cycle(1'b1, 0, 1'b0, 1'b1, 0, 0, 1'b0, 0);
        chk("w0_net0_total", 32'(total_pending), 32'd17);

        // Commit of the last pending instruction reads as drained that cycle
        cycle(1'b1, 1, 1'b0, 1'b0, 0, 1, 1'b0, 0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1, 1, 1'b0, 0);
        chk("w1_drain_alm", 32'(alm_empty), 32'd1);

        // Lock / unlock on warp 3, then lock wins over same-cycle unlock
        cycle(1'b1, 3, 1'b1, 1'b0, 0, 3, 1'b0, 0);
        chk("lock_mask", 32'(locked_mask), 32'h8);
        cycle(1'b1, 3, 1'b0, 1'b0, 0, 3, 1'b0, 0);
        chk("locked_ready", 32'(issue_ready), 32'd0);
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 3);
        chk("unlock_mask", 32'(locked_mask), 32'h0);
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 3);
        cycle(1'b1, 3, 1'b1, 1'b0, 0, 0, 1'b1, 3);
        chk("lock_wins", 32'(locked_mask), 32'h8);
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 3);

        // Underflow on empty warp 1 is sticky
        cycle(1'b0, 0, 1'b0, 1'b1, 1, 1, 1'b0, 0);
        chk("underflow_set", 32'(underflow_err), 32'd1);
        idle();
        chk("underflow_sticky", 32'(underflow_err), 32'd1);
        // Same-warp issue + commit at zero must not flag
        @(posedge clk); #1; reset = 1'b0; #1; model_reset();
        @(posedge clk); #1; reset = 1'b1;
        chk("underflow_cleared", 32'(underflow_err), 32'd0);
        cycle(1'b1, 2, 1'b0, 1'b1, 2, 2, 1'b0, 0);
        chk("cancel_no_uf", 32'(underflow_err), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-cycle with warp 2 at 5 and warp 0 locked
        @(posedge clk); #1; reset = 1'b0; #1; model_reset();
        @(posedge clk); #1; reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 2, 1'b0, 1'b0, 0, 2, 1'b0, 0);
        cycle(1'b1, 0, 1'b1, 1'b0, 0, 2, 1'b0, 0);
        chk("pre_async_mask", 32'(locked_mask), 32'h1);
        chk("pre_async_total", 32'(total_pending), 32'd5);
        issue_valid = 1'b0; issue_wid = 2'd2; issue_lock = 1'b0;
        alm_empty_wid = 2'd2;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_mask", 32'(locked_mask), 32'd0);
        chk("async_total", 32'(total_pending), 32'd0);
        chk("async_underflow", 32'(underflow_err), 32'd0);
        chk("async_alm_empty", 32'(alm_empty), 32'd1);
        chk("async_ready", 32'(issue_ready), 32'd1);
        @(posedge clk); #1; reset = 1'b1;
        idle();
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 2, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
